// File: rtl/decimal_entry.sv
// Four-digit decimal entry from debounced push buttons, with a sequential
// BCD-to-binary converter and a multiplexed 7-segment display.
//
// state | meaning
// IDLE  | no conversion pending; led/ovf hold the last result
// CONV  | four accumulate steps, thousands digit first
// DONE  | publish acc to led/ovf, then return to IDLE
module decimal_entry #(
    parameter int N               = 13,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_BIT       = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btnU,
    input  logic         btnD,
    input  logic         btnL,
    input  logic         btnR,
    input  logic         btnC,
    output logic [N-1:0] led,
    output logic         ovf,
    output logic         busy,
    output logic [3:0]   an,
    output logic [6:0]   seg
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] MAXV = (N >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    // button bit order doubles as event priority: C, U, D, L, R
    logic [4:0]    btn_raw, sync1, sync2, level, level_q, press;
    logic [DW-1:0] db_cnt [5];
    logic [3:0]    digit [4];
    logic [1:0]    cursor;
    logic          start;

    state_t        state, state_nx;
    logic [13:0]   acc, acc_nx;
    logic [1:0]    step, step_nx;
    logic [N-1:0]  led_nx;
    logic          ovf_nx;

    logic [19:0]        refresh;
    logic [BLINK_BIT:0] blink;
    logic [1:0]         sel;
    logic [3:0]         an_nx;
    logic [6:0]         seg_nx;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    assign btn_raw = {btnR, btnL, btnD, btnU, btnC};
    assign press   = level & ~level_q;
    assign start   = press[0] | press[1] | press[2];
    assign busy    = (state != IDLE);
    assign sel     = refresh[19:18];

    // two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // debounce: the counter reloads whenever the input agrees with the level;
    // a cleared count is harmless because sync2 still agrees on the first edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            level_q <= level;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= DB_LAST;
                end else if (db_cnt[i] == '0) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= DB_LAST;
                end else begin
                    db_cnt[i] <= db_cnt[i] - DW'(1);
                end
            end
        end
    end

    // digit and cursor editing, highest-priority event only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
            cursor <= 2'd0;
        end else if (press[0]) begin
            for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
            cursor <= 2'd0;
        end else if (press[1]) begin
            digit[cursor] <= (digit[cursor] == 4'd9) ? 4'd0 : digit[cursor] + 4'd1;
        end else if (press[2]) begin
            digit[cursor] <= (digit[cursor] == 4'd0) ? 4'd9 : digit[cursor] - 4'd1;
        end else if (press[3]) begin
            cursor <= cursor + 2'd1;
        end else if (press[4]) begin
            cursor <= cursor - 2'd1;
        end
    end

    // converter state and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            step  <= '0;
            led   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            step  <= step_nx;
            led   <= led_nx;
            ovf   <= ovf_nx;
        end
    end

    // converter next state; a new edit restarts from scratch and suppresses the publish
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        step_nx  = step;
        led_nx   = led;
        ovf_nx   = ovf;
        if (start) begin
            state_nx = CONV;
            acc_nx   = '0;
            step_nx  = 2'd3;
        end else begin
            case (state)
                CONV: begin
                    acc_nx  = acc * 14'd10 + {10'd0, digit[step]};
                    step_nx = step - 2'd1;
                    if (step == 2'd0) state_nx = DONE;
                end
                DONE: begin
                    state_nx = IDLE;
                    if ({18'd0, acc} <= MAXV) begin
                        led_nx = N'(acc);
                        ovf_nx = 1'b0;
                    end else begin
                        led_nx = '1;
                        ovf_nx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // free-running refresh and blink counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh <= '0;
            blink   <= '0;
        end else begin
            refresh <= refresh + 20'd1;
            blink   <= blink + (BLINK_BIT + 1)'(1);
        end
    end

    // anode and segment pattern for the digit being scanned
    always_comb begin
        an_nx  = ~(4'b0001 << sel);
        seg_nx = seg_code(digit[sel]);
        if (sel == cursor && blink[BLINK_BIT]) seg_nx = 7'b1111111;
    end

    // registered display drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
        end
    end
endmodule
